// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encodings, ACK/NACK levels, byte and bit-count sizes.
// The master-side stages use this package as well.
package i2c_pkg;

  localparam int BYTE_W = 8;
  localparam logic [3:0] BIT_CNT_MAX = 4'd8;

  localparam logic ACK      = 1'b0;
  localparam logic NACK     = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ACK_ADDR = 3'd2,
    ST_DATA     = 3'd3,
    ST_ACK_DATA = 3'd4,
    ST_IGNORE   = 3'd5
  } i2c_rx_state_e;

  // The open-drain output pulls SDA low for any bit value other than NACK.
  function automatic logic pull_low(input logic ack_bit);
    return ack_bit != NACK;
  endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchroniser for an asynchronous I2C line, followed by a one-flop edge detector.
// Flops reset to the idle bus level so that releasing reset on an idle bus produces no edges.
module i2c_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b1
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic Din,
  output logic Dout,
  output logic Rise,
  output logic Fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], Din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign Dout = sync_q[SYNC_STAGES-1];
  assign Rise = Dout & ~prev_q;
  assign Fall = ~Dout & prev_q;

endmodule

// File: rtl/i2c_slave_rx.sv
// Slave-side I2C write receiver: address match, byte deserialisation, ACK drive and
// a one-cycle parallel strobe per received data byte.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | bus free, waiting for START
// ST_ADDR     | shifting in the 7-bit address plus R/W bit
// ST_ACK_ADDR | driving ACK for a matched write address on the 9th bit
// ST_DATA     | shifting in a data byte
// ST_ACK_DATA | driving ACK for a received data byte on the 9th bit
// ST_IGNORE   | not addressed (or read request); waits for STOP/START
module i2c_slave_rx
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR        = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Scl,
  input  logic              Sda_in,
  output logic              Sda_oe,
  output logic [BYTE_W-1:0] Data_out,
  output logic              Data_valid,
  output logic              Addr_match,
  output logic              Busy
);

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_rx_state_e     state;
  logic [3:0]        bit_cnt;
  logic [BYTE_W-1:0] shreg;
  logic [BYTE_W-1:0] shift_next;
  logic              last_bit;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_scl_sync (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Din   (Scl),
    .Dout  (scl_s),
    .Rise  (scl_rise),
    .Fall  (scl_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sda_sync (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Din   (Sda_in),
    .Dout  (sda_s),
    .Rise  (sda_rise),
    .Fall  (sda_fall)
  );

  assign start_det  = sda_fall & scl_s;
  assign stop_det   = sda_rise & scl_s;
  assign shift_next = {shreg[BYTE_W-2:0], sda_s};
  assign last_bit   = (bit_cnt == BIT_CNT_MAX - 4'd1);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= 4'd0;
      shreg      <= '0;
      Data_out   <= '0;
      Data_valid <= 1'b0;
      Sda_oe     <= 1'b0;
      Addr_match <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      Data_valid <= 1'b0;
      if (start_det) begin
        state      <= ST_ADDR;
        bit_cnt    <= 4'd0;
        shreg      <= '0;
        Sda_oe     <= 1'b0;
        Addr_match <= 1'b0;
        Busy       <= 1'b1;
      end else if (stop_det) begin
        state      <= ST_IDLE;
        bit_cnt    <= 4'd0;
        shreg      <= '0;
        Sda_oe     <= 1'b0;
        Addr_match <= 1'b0;
        Busy       <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: begin
            if (scl_rise) begin
              shreg   <= shift_next;
              bit_cnt <= bit_cnt + 4'd1;
              if (last_bit) begin
                // Reads are not supported, so a read to our own address is left un-ACKed.
                if (shift_next[BYTE_W-1:1] == ADDR && shift_next[0] == RW_WRITE)
                  state <= ST_ACK_ADDR;
                else
                  state <= ST_IGNORE;
              end
            end
          end
          ST_DATA: begin
            if (scl_rise) begin
              shreg   <= shift_next;
              bit_cnt <= bit_cnt + 4'd1;
              if (last_bit) begin
                Data_out   <= shift_next;
                Data_valid <= 1'b1;
                state      <= ST_ACK_DATA;
              end
            end
          end
          ST_ACK_ADDR, ST_ACK_DATA: begin
            // First SCL fall opens the ACK slot, the second one closes it.
            if (scl_fall) begin
              if (!Sda_oe) begin
                Sda_oe     <= pull_low(ACK);
                Addr_match <= 1'b1;
              end else begin
                Sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
                state   <= ST_DATA;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Directed bench for i2c_slave_rx: a table of write frames plus hand-written
// sequences for reset, repeated START and early STOP.
module tb_i2c_slave_rx;
  import i2c_pkg::*;

  localparam int H = 8;
  localparam int OE_CYCLES = 2 * (2 * H + 2);

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       Scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       Sda_in;
  logic       Sda_oe;
  logic [7:0] Data_out;
  logic       Data_valid;
  logic       Addr_match;
  logic       Busy;

  assign Sda_in = sda_m & ~Sda_oe;

  i2c_slave_rx #(.ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Scl        (Scl),
    .Sda_in     (Sda_in),
    .Sda_oe     (Sda_oe),
    .Data_out   (Data_out),
    .Data_valid (Data_valid),
    .Addr_match (Addr_match),
    .Busy       (Busy)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad = 0;
  int dv_cnt = 0;
  int oe_cnt = 0;
  logic [7:0] dv_last = 8'h00;

  always @(negedge Clk) begin
    if (Rst_n) begin
      if (Data_valid) begin
        dv_cnt  = dv_cnt + 1;
        dv_last = Data_out;
      end
      if (Sda_oe) oe_cnt = oe_cnt + 1;
    end
  end

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       exp_aack;
    logic       exp_dack;
    int         exp_dv;
    logic [7:0] exp_dout;
    logic       exp_match;
    int         exp_oe;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Works both from an idle bus and as a repeated START from SCL low.
  task automatic bus_start();
    sda_m = 1'b1;
    wait_clk(H);
    Scl = 1'b1;
    wait_clk(H);
    sda_m = 1'b0;
    wait_clk(H);
    Scl = 1'b0;
    wait_clk(2);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      sda_m = b[7-i];
      wait_clk(H);
      Scl = 1'b1;
      wait_clk(H);
      Scl = 1'b0;
      wait_clk(2);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    send_bits(b, 8);
    sda_m = 1'b1;
    wait_clk(H);
    Scl = 1'b1;
    wait_clk(H - 1);
    acked = ~Sda_in;
    wait_clk(1);
    Scl = 1'b0;
    wait_clk(H);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0;
    wait_clk(H);
    Scl = 1'b1;
    wait_clk(H);
    sda_m = 1'b1;
    wait_clk(H);
  endtask

  initial begin
    logic ack;
    int   dv_base;
    int   oe_base;

    vecs[0] = '{8'hA0, 8'h3C, 1'b1, 1'b1, 1, 8'h3C, 1'b1, OE_CYCLES};
    vecs[1] = '{8'hA2, 8'h12, 1'b0, 1'b0, 0, 8'h3C, 1'b0, 0};
    vecs[2] = '{8'hA1, 8'h34, 1'b0, 1'b0, 0, 8'h3C, 1'b0, 0};
    vecs[3] = '{8'hA0, 8'hFF, 1'b1, 1'b1, 1, 8'hFF, 1'b1, OE_CYCLES};
    vecs[4] = '{8'h20, 8'h77, 1'b0, 1'b0, 0, 8'hFF, 1'b0, 0};
    vecs[5] = '{8'hA0, 8'h00, 1'b1, 1'b1, 1, 8'h00, 1'b1, OE_CYCLES};

    wait_clk(3);
    check("rst_sda_oe", 32'(Sda_oe), 0);
    check("rst_data_out", 32'(Data_out), 0);
    check("rst_data_valid", 32'(Data_valid), 0);
    check("rst_addr_match", 32'(Addr_match), 0);
    check("rst_busy", 32'(Busy), 0);
    check("rst_state", 32'(dut.state), 32'(ST_IDLE));
    Rst_n = 1'b1;
    wait_clk(H);

    for (int v = 0; v < 6; v++) begin
      dv_base = dv_cnt;
      oe_base = oe_cnt;
      bus_start();
      check($sformatf("v%0d_busy_start", v), 32'(Busy), 1);
      send_byte(vecs[v].addr, ack);
      check($sformatf("v%0d_addr_ack", v), 32'(ack), 32'(vecs[v].exp_aack));
      check($sformatf("v%0d_addr_match", v), 32'(Addr_match), 32'(vecs[v].exp_match));
      send_byte(vecs[v].data, ack);
      check($sformatf("v%0d_data_ack", v), 32'(ack), 32'(vecs[v].exp_dack));
      check($sformatf("v%0d_dv_count", v), 32'(dv_cnt - dv_base), 32'(vecs[v].exp_dv));
      check($sformatf("v%0d_data_out", v), 32'(Data_out), 32'(vecs[v].exp_dout));
      bus_stop();
      check($sformatf("v%0d_busy_stop", v), 32'(Busy), 0);
      check($sformatf("v%0d_match_stop", v), 32'(Addr_match), 0);
      check($sformatf("v%0d_oe_cycles", v), 32'(oe_cnt - oe_base), 32'(vecs[v].exp_oe));
    end

    // Reset in the middle of a data byte
    dv_base = dv_cnt;
    bus_start();
    send_byte(8'hA0, ack);
    send_bits(8'h96, 4);
    Rst_n = 1'b0;
    #1;
    check("mid_rst_sda_oe", 32'(Sda_oe), 0);
    check("mid_rst_data_out", 32'(Data_out), 0);
    check("mid_rst_data_valid", 32'(Data_valid), 0);
    check("mid_rst_addr_match", 32'(Addr_match), 0);
    check("mid_rst_busy", 32'(Busy), 0);
    check("mid_rst_state", 32'(dut.state), 32'(ST_IDLE));
    check("mid_rst_no_dv", 32'(dv_cnt - dv_base), 0);
    sda_m = 1'b1;
    Scl = 1'b1;
    wait_clk(4);
    Rst_n = 1'b1;
    wait_clk(H);
    dv_base = dv_cnt;
    bus_start();
    send_byte(8'hA0, ack);
    check("post_rst_addr_ack", 32'(ack), 1);
    send_byte(8'h5A, ack);
    check("post_rst_data_ack", 32'(ack), 1);
    bus_stop();
    check("post_rst_dv_count", 32'(dv_cnt - dv_base), 1);
    check("post_rst_data_out", 32'(Data_out), 32'h5A);

    // Repeated START between two write frames
    dv_base = dv_cnt;
    bus_start();
    send_byte(8'hA0, ack);
    send_byte(8'h55, ack);
    check("rs_first_dv", 32'(dv_cnt - dv_base), 1);
    check("rs_first_data", 32'(dv_last), 32'h55);
    check("rs_match_before", 32'(Addr_match), 1);
    bus_start();
    check("rs_match_dropped", 32'(Addr_match), 0);
    check("rs_busy_held", 32'(Busy), 1);
    send_byte(8'hA0, ack);
    check("rs_addr_ack", 32'(ack), 1);
    check("rs_match_again", 32'(Addr_match), 1);
    send_byte(8'hFF, ack);
    bus_stop();
    check("rs_dv_total", 32'(dv_cnt - dv_base), 2);
    check("rs_last_data", 32'(Data_out), 32'hFF);

    // STOP after five data bits
    dv_base = dv_cnt;
    bus_start();
    send_byte(8'hA0, ack);
    send_bits(8'hC3, 5);
    bus_stop();
    check("early_stop_sda_oe", 32'(Sda_oe), 0);
    check("early_stop_busy", 32'(Busy), 0);
    check("early_stop_match", 32'(Addr_match), 0);
    check("early_stop_no_dv", 32'(dv_cnt - dv_base), 0);
    check("early_stop_data_kept", 32'(Data_out), 32'hFF);
    check("early_stop_state", 32'(dut.state), 32'(ST_IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_slave_rx.md
# i2c_slave_rx

Slave-side I2C receive stage: the serial consumer of the byte stream shifted out MSB-first by the master's parallel-load/serial-out shift register. It oversamples SCL/SDA on the system clock, detects START/STOP, deserialises the address and data bytes, drives ACK/NACK, and presents each received data byte as a one-cycle parallel strobe to the slave register file.

## Interface
- `ADDR`, default 7'h50: 7-bit slave address to match.
- `SYNC_STAGES`, default 2: flip-flop stages in the SCL/SDA synchronisers (min 2).
- `Clk`  in  1  system clock; all state on rising edge.
- `Rst_n`  in  1  reset, asynchronous, active-low.
- `Scl`  in  1  I2C clock line (asynchronous to Clk).
- `Sda_in`  in  1  I2C data line, input side of open-drain pad.
- `Sda_oe`  out  1  1 = pull SDA low (ACK); 0 = release.
- `Data_out`  out  8  last received data byte, MSB first on the wire.
- `Data_valid`  out  1  one-Clk pulse, Data_out newly updated.
- `Addr_match`  out  1  high from ACKed address until STOP or next START.
- `Busy`  out  1  high between START and STOP.

## Operation
- Reset (Rst_n=0, any time, asynchronous): state IDLE, bit counter 0, shift register 8'h00, Data_out 8'h00, Sda_oe/Data_valid/Addr_match/Busy 0. Mid-transfer reset aborts the byte; no Data_valid issued.
- SCL/SDA pass through SYNC_STAGES synchronisers then a 1-flop edge detector; all decisions use synchronised values.
- START = synchronised SDA falls while SCL high. STOP = SDA rises while SCL high. Both are recognised in every state, override all other activity, and take priority over bit sampling in the same cycle.
- States: IDLE, ADDR, ACK_ADDR, DATA, ACK_DATA, IGNORE.
  - IDLE: START -> ADDR, Busy=1, counter=0.
  - ADDR: each SCL rise shifts SDA into LSB (shift left); after 8th rise compare bits[7:1] with ADDR and bit[0] (R/W). Match and R/W=0 -> ACK_ADDR. Otherwise (mismatch, or read request—reads unsupported) -> IGNORE, SDA never driven.
  - ACK_ADDR: on next SCL fall assert Sda_oe, Addr_match=1; on following SCL fall release Sda_oe -> DATA, counter=0.
  - DATA: shift 8 bits as in ADDR; on 8th rise Data_out <= shifted byte, Data_valid pulses 1 cycle -> ACK_DATA.
  - ACK_DATA: identical ACK drive to ACK_ADDR -> DATA. Slave always ACKs data.
  - IGNORE: no drive, waits for STOP or START.
- Repeated START (any state): -> ADDR, counter=0, Addr_match=0, Sda_oe=0, partial byte discarded.
- STOP (any state): -> IDLE, Busy=0, Addr_match=0, Sda_oe=0 same cycle; partial byte discarded.
- Counter is 4 bits, 0..8, cleared on entry to ADDR/DATA; no wrap.

## Timing
- Sampling latency: SDA captured SYNC_STAGES+1 Clk cycles after the pin-level SCL rise (3 at default).
- Data_valid/Data_out: same Clk cycle as the detected 8th SCL rise of a data byte; Data_out holds until next byte.
- Sda_oe asserts SYNC_STAGES+1 cycles after the 8th-bit SCL fall, deasserts SYNC_STAGES+1 cycles after the 9th-bit SCL fall.
- Requirement: each SCL high and low phase >= SYNC_STAGES+2 Clk cycles; SDA changes only while SCL low except START/STOP.
- All outputs registered; no combinational input-to-output path.

## Structure
- Shared package `i2c_pkg`: state encodings, ACK=1'b0/NACK=1'b1 constants, byte width 8, bit-count limit 8; also used by the master-side stages.
- One sub-module: `i2c_sync_edge` (synchroniser + rise/fall detect), instantiated for SCL and SDA.

## Test plan
- Reset mid-DATA after 4 bits -> all outputs 0, state IDLE; next full transfer received correctly.
- START, byte 8'hA0 (ADDR 7'h50, W), byte 8'h3C, STOP -> ACK on both 9th bits, one Data_valid with Data_out=8'h3C, Busy falls on STOP.
- START, address 8'hA2 (mismatch) -> Sda_oe stays 0 whole frame, no Data_valid, Addr_match 0.
- START, 8'hA1 (read to own address) -> NACK, IGNORE until STOP.
- START, 8'hA0, 8'h55, repeated START, 8'hA0, 8'hFF, STOP -> Data_valid twice (8'h55, 8'hFF), Addr_match drops for the repeated address phase.
- STOP inserted after 5 data bits -> Sda_oe 0, Busy 0, no Data_valid, Data_out keeps previous byte.
